serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor computing `diff = a - b` one bit per clock, LSB first, with a registered borrow flip-flop carried between bit-cycles. It is the inverse-operation counterpart to the team's ripple full-adder datapath. It sits beside the arithmetic unit wherever area matters more than latency. A start/busy/done handshake lets a controller FSM issue one operation at a time and collect the result.

---
 rtl/serial_subtractor.sv | 141 ++++++++++++++
 tb/tb_serial_subtractor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, with a start/busy/done handshake.
// Optional signed-overflow output `ovf` is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic ai, bi, d_bit, br_nxt, last_bit;

    assign ai       = a_q[0];
    assign bi       = b_q[0];
    assign d_bit    = ai ^ bi ^ br_q;
    assign br_nxt   = (~ai & bi) | (~(ai ^ bi) & br_q);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        br_d     = br_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // DONE accepts a new start too, giving back-to-back operations
                if (start) begin
                    state_d  = RUN;
                    a_d      = a;
                    b_d      = b;
                    br_d     = 1'b0;
                    cnt_d    = '0;
                    diff_d   = '0;
                    borrow_d = 1'b0;
                    busy_d   = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = br_nxt;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d  = DONE;
                    borrow_d = br_nxt;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    // operand MSBs sit at the LSB position on the final bit-cycle
                    ovf_d    = (ai ^ bi) & (ai ^ d_bit);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            br_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            br_q     <= br_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, handshake corner cases,
// and random operands against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } vec_t;

    vec_t tbl[9];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed views of the operands.
    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output logic [W-1:0] d, output logic br, output logic ov);
        int ua, ub, sa, sb, r, sr;
        ua = int'(av);
        ub = int'(bv);
        sa = $signed(av);
        sb = $signed(bv);
        r  = ua - ub;
        sr = sa - sb;
        d  = r[W-1:0];
        br = (ua < ub);
        ov = (sr > 127) || (sr < -128);
    endfunction

    // Entered at the falling edge just after the accepting clock edge; leaves at the done cycle.
    task automatic wait_result(input string nm, input logic [W-1:0] ed, input logic eb, input logic eo);
        int cyc;
        int busy_cyc;
        cyc = 0;
        busy_cyc = 0;
        while (!done && cyc < W + 4) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, cyc, W);
        chk({nm, "_busy_cycles"}, busy_cyc, W);
        chk({nm, "_busy_at_done"}, 32'(busy), 0);
        chk({nm, "_diff"}, 32'(diff), 32'(ed));
        chk({nm, "_borrow"}, 32'(borrow), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: unknown overflow expectation for %s", nm);
`endif
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb, input logic eo);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result(nm, ed, eb, eo);
        @(negedge clk);
        chk({nm, "_done_fall"}, 32'(done), 0);
        chk({nm, "_diff_hold"}, 32'(diff), 32'(ed));
    endtask

    initial begin
        logic [W-1:0] md;
        logic         mb, mo;
        logic [W-1:0] ra, rb;
        int           ndone, done_at;
        logic [W-1:0] got;

        tbl[0] = '{8'h35, 8'h12, 8'h23, 1'b0, 1'b0};
        tbl[1] = '{8'h12, 8'h35, 8'hDD, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        tbl[4] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[6] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        tbl[7] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};
        tbl[8] = '{8'hA0, 8'h0A, 8'h96, 1'b0, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_diff", 32'(diff), 0);
        chk("rst_borrow", 32'(borrow), 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 32'(ovf), 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        for (int i = 0; i < 9; i++) begin
            do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].diff, tbl[i].borrow, tbl[i].ovf);
        end

        // start pulse while busy must be ignored
        a = 8'h35; b = 8'h12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; done_at = -1; got = '0;
        for (int n = 1; n <= 20; n++) begin
            if (n == 3) begin a = 8'hFF; b = 8'h00; start = 1'b1; end
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ndone++;
                if (done_at < 0) begin done_at = n; got = diff; end
            end
        end
        chk("ign_done_count", ndone, 1);
        chk("ign_done_at", done_at, W);
        chk("ign_diff", 32'(got), 32'h23);

        // reset mid-operation aborts without a done
        a = 8'h35; b = 8'h12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_diff", 32'(diff), 0);
        chk("abort_borrow", 32'(borrow), 0);
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("abort_no_activity", ndone, 0);
        do_op("after_abort", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

        // back-to-back: start held during the DONE cycle
        a = 8'h35; b = 8'h12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result("b2b_first", 8'h23, 1'b0, 1'b0);
        a = 8'hA0; b = 8'h0A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_rise", 32'(busy), 1);
        chk("b2b_done_low", 32'(done), 0);
        chk("b2b_diff_cleared", 32'(diff), 0);
        wait_result("b2b_second", 8'h96, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_done_fall", 32'(done), 0);

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            model(ra, rb, md, mb, mo);
            do_op($sformatf("rnd%0d", i), ra, rb, md, mb, mo);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
